// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch
// Purpose  : Program counter, combinational-ROM addressing, and a 2-entry
//            prefetch buffer feeding decode. Redirects flush the buffer and
//            reload the PC.
// Revision : 1.0 - initial release
// ============================================================================
module instr_fetch #(
  parameter int unsigned     AW       = 8,
  parameter int unsigned     DW       = 16,
  parameter logic [AW-1:0]   RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic [AW-1:0] rom_addr,
  input  logic [DW-1:0] rom_data,
  input  logic          redirect_valid,
  input  logic [AW-1:0] redirect_pc,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_instr,
  output logic [AW-1:0] out_pc
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  localparam logic [AW-1:0] c_pc_step = AW'(1);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [AW-1:0] r_pc;
  logic [AW-1:0] w_pc_nxt;
  logic [AW-1:0] r_head_pc;
  logic [AW-1:0] w_head_pc_nxt;
  logic [DW-1:0] r_head_instr;
  logic [DW-1:0] w_head_instr_nxt;
  logic [AW-1:0] r_tail_pc;
  logic [AW-1:0] w_tail_pc_nxt;
  logic [DW-1:0] r_tail_instr;
  logic [DW-1:0] w_tail_instr_nxt;
  logic          w_pop;
  logic          w_push;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_EMPTY;
      r_pc         <= RESET_PC;
      r_head_pc    <= '0;
      r_head_instr <= '0;
      r_tail_pc    <= '0;
      r_tail_instr <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_head_pc    <= w_head_pc_nxt;
      r_head_instr <= w_head_instr_nxt;
      r_tail_pc    <= w_tail_pc_nxt;
      r_tail_instr <= w_tail_instr_nxt;
    end
  end

  always_comb begin
    w_pop            = (r_state != S_EMPTY) & out_ready;
    w_push           = !redirect_valid & ((r_state != S_FULL) | w_pop);
    w_state_nxt      = r_state;
    w_pc_nxt         = r_pc;
    w_head_pc_nxt    = r_head_pc;
    w_head_instr_nxt = r_head_instr;
    w_tail_pc_nxt    = r_tail_pc;
    w_tail_instr_nxt = r_tail_instr;

    if (redirect_valid) begin
      // Flush clears the slots so an empty head always reads back as zero.
      w_state_nxt      = S_EMPTY;
      w_pc_nxt         = redirect_pc;
      w_head_pc_nxt    = '0;
      w_head_instr_nxt = '0;
      w_tail_pc_nxt    = '0;
      w_tail_instr_nxt = '0;
    end else begin
      if (w_push) begin
        w_pc_nxt = r_pc + c_pc_step;
      end
      unique case (r_state)
        S_EMPTY: begin
          if (w_push) begin
            w_state_nxt      = S_ONE;
            w_head_pc_nxt    = r_pc;
            w_head_instr_nxt = rom_data;
          end
        end
        S_ONE: begin
          if (w_push && w_pop) begin
            w_head_pc_nxt    = r_pc;
            w_head_instr_nxt = rom_data;
          end else if (w_push) begin
            w_state_nxt      = S_FULL;
            w_tail_pc_nxt    = r_pc;
            w_tail_instr_nxt = rom_data;
          end else if (w_pop) begin
            w_state_nxt      = S_EMPTY;
            w_head_pc_nxt    = '0;
            w_head_instr_nxt = '0;
          end
        end
        S_FULL: begin
          // A push from FULL is only possible alongside a pop.
          if (w_pop) begin
            w_head_pc_nxt    = r_tail_pc;
            w_head_instr_nxt = r_tail_instr;
            if (w_push) begin
              w_tail_pc_nxt    = r_pc;
              w_tail_instr_nxt = rom_data;
            end else begin
              w_state_nxt      = S_ONE;
              w_tail_pc_nxt    = '0;
              w_tail_instr_nxt = '0;
            end
          end
        end
        default: begin
          w_state_nxt      = S_EMPTY;
          w_head_pc_nxt    = '0;
          w_head_instr_nxt = '0;
          w_tail_pc_nxt    = '0;
          w_tail_instr_nxt = '0;
        end
      endcase
    end
  end

  assign rom_addr  = r_pc;
  assign out_valid = (r_state != S_EMPTY);
  assign out_pc    = r_head_pc;
  assign out_instr = r_head_instr;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch
// Purpose  : Self-checking bench for instr_fetch with a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_fetch;

  logic        clk;
  logic        rst_n;
  logic [7:0]  rom_addr;
  logic [15:0] rom_data;
  logic        redirect_valid;
  logic [7:0]  redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_instr;
  logic [7:0]  out_pc;

  logic [15:0] rom [256];

  int n_tests;
  int n_fail;

  // Reference model: a bounded queue of fetched entries and a PC.
  logic [7:0]  q_pc [$];
  logic [15:0] q_in [$];
  logic [7:0]  m_pc;

  instr_fetch #(.AW(8), .DW(16), .RESET_PC(8'h00)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc)
  );

  assign rom_data = rom[rom_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    q_pc.delete();
    q_in.delete();
    m_pc = 8'h00;
  endtask

  // Drive one cycle of inputs, advance the model, then sample 1 time unit after the edge.
  task automatic step(input bit rdy, input bit rv, input logic [7:0] tgt);
    bit pop;
    out_ready      = rdy;
    redirect_valid = rv;
    redirect_pc    = tgt;
    pop = (q_pc.size() > 0) && rdy;
    if (rv) begin
      q_pc.delete();
      q_in.delete();
      m_pc = tgt;
    end else begin
      if (pop) begin
        void'(q_pc.pop_front());
        void'(q_in.pop_front());
      end
      if (q_pc.size() < 2) begin
        q_pc.push_back(m_pc);
        q_in.push_back(rom[m_pc]);
        m_pc = m_pc + 8'h01;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #3;
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b0;
    redirect_valid = 1'b0;
  endtask

  task automatic test_reset();
    out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 8'h00;
    rst_n = 1'b0;
    model_reset();
    #12;
    n_tests++;
    if (out_valid !== 1'b0 || out_instr !== 16'h0 || out_pc !== 8'h00 || rom_addr !== 8'h00) begin
      n_fail++;
      $display("FAIL reset: valid=%b instr=%h pc=%h addr=%h, required 0/0000/00/00", out_valid, out_instr, out_pc, rom_addr);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_stream();
    logic [7:0] exp_pc [3];
    logic [15:0] exp_in [3];
    exp_pc = '{8'h00, 8'h01, 8'h02};
    exp_in = '{16'hC000, 16'hC800, 16'hD002};
    step(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if (out_valid !== 1'b1 || out_pc !== exp_pc[i] || out_instr !== exp_in[i]) begin
        n_fail++;
        $display("FAIL stream[%0d]: valid=%b pc=%h instr=%h, required 1/%h/%h", i, out_valid, out_pc, out_instr, exp_pc[i], exp_in[i]);
      end
      step(1'b1, 1'b0, 8'h00);
    end
    for (int i = 0; i < 5; i++) begin
      n_tests++;
      if (out_valid !== 1'b1 || out_pc !== q_pc[0] || out_instr !== q_in[0]) begin
        n_fail++;
        $display("FAIL stream_gapless[%0d]: valid=%b pc=%h instr=%h, required 1/%h/%h", i, out_valid, out_pc, out_instr, q_pc[0], q_in[0]);
      end
      step(1'b1, 1'b0, 8'h00);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] got [4];
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 8'h00);
    n_tests++;
    if (out_valid !== 1'b1 || out_pc !== 8'h00 || out_instr !== 16'hC000 || rom_addr !== 8'h02) begin
      n_fail++;
      $display("FAIL backpressure_hold: valid=%b pc=%h instr=%h addr=%h, required 1/00/C000/02", out_valid, out_pc, out_instr, rom_addr);
    end
    for (int i = 0; i < 4; i++) begin
      got[i] = out_valid ? out_pc : 8'hXX;
      step(1'b1, 1'b0, 8'h00);
    end
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (got[i] !== 8'(i)) begin
        n_fail++;
        $display("FAIL backpressure_drain[%0d]: pc=%h, required %h", i, got[i], 8'(i));
      end
    end
  endtask

  task automatic test_wrap_redirect();
    step(1'b1, 1'b1, 8'hFF);
    n_tests++;
    if (out_valid !== 1'b0 || rom_addr !== 8'hFF || out_pc !== 8'h00 || out_instr !== 16'h0) begin
      n_fail++;
      $display("FAIL wrap_bubble: valid=%b addr=%h pc=%h instr=%h, required 0/FF/00/0000", out_valid, rom_addr, out_pc, out_instr);
    end
    step(1'b1, 1'b0, 8'h00);
    n_tests++;
    if (out_valid !== 1'b1 || out_pc !== 8'hFF || out_instr !== 16'h9800) begin
      n_fail++;
      $display("FAIL wrap_target: valid=%b pc=%h instr=%h, required 1/FF/9800", out_valid, out_pc, out_instr);
    end
    step(1'b1, 1'b0, 8'h00);
    n_tests++;
    if (out_valid !== 1'b1 || out_pc !== 8'h00 || out_instr !== 16'hC000) begin
      n_fail++;
      $display("FAIL wrap_next: valid=%b pc=%h instr=%h, required 1/00/C000", out_valid, out_pc, out_instr);
    end
  endtask

  task automatic test_redirect_full();
    do_reset();
    step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 8'h00);
    n_tests++;
    if (rom_addr !== 8'h02 || out_pc !== 8'h00) begin
      n_fail++;
      $display("FAIL full_state: addr=%h pc=%h, required 02/00", rom_addr, out_pc);
    end
    step(1'b1, 1'b1, 8'h0D);
    n_tests++;
    if (out_valid !== 1'b0 || rom_addr !== 8'h0D) begin
      n_fail++;
      $display("FAIL full_redirect_bubble: valid=%b addr=%h, required 0/0D", out_valid, rom_addr);
    end
    step(1'b1, 1'b0, 8'h00);
    n_tests++;
    if (out_valid !== 1'b1 || out_pc !== 8'h0D || out_instr !== 16'h6C51) begin
      n_fail++;
      $display("FAIL full_redirect_target: valid=%b pc=%h instr=%h, required 1/0D/6C51", out_valid, out_pc, out_instr);
    end
  endtask

  task automatic test_async_reset();
    step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h00);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_tests++;
    if (out_valid !== 1'b0 || rom_addr !== 8'h00 || out_pc !== 8'h00 || out_instr !== 16'h0) begin
      n_fail++;
      $display("FAIL async_reset: valid=%b addr=%h pc=%h instr=%h, required 0/00/00/0000", out_valid, rom_addr, out_pc, out_instr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 1'b0, 8'h00);
    n_tests++;
    if (out_valid !== 1'b1 || out_pc !== 8'h00 || out_instr !== 16'hC000) begin
      n_fail++;
      $display("FAIL async_restart: valid=%b pc=%h instr=%h, required 1/00/C000", out_valid, out_pc, out_instr);
    end
  endtask

  task automatic test_redirect_pop_one();
    logic [7:0] tgt;
    tgt = 8'($urandom_range(1, 254));
    do_reset();
    step(1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b1, tgt);
    n_tests++;
    if (out_valid !== 1'b0 || rom_addr !== tgt || q_pc.size() != 0) begin
      n_fail++;
      $display("FAIL pop_redirect_empty: valid=%b addr=%h, required 0/%h", out_valid, rom_addr, tgt);
    end
    step(1'b0, 1'b0, 8'h00);
    n_tests++;
    if (out_valid !== 1'b1 || out_pc !== tgt || out_instr !== rom[tgt]) begin
      n_fail++;
      $display("FAIL pop_redirect_next: valid=%b pc=%h instr=%h, required 1/%h/%h", out_valid, out_pc, out_instr, tgt, rom[tgt]);
    end
  endtask

  task automatic test_random();
    bit rdy, rv;
    logic [7:0] tgt;
    bit mv;
    logic [7:0] mp;
    logic [15:0] mi;
    for (int i = 0; i < 400; i++) begin
      rdy = ($urandom_range(0, 9) < 7);
      rv  = ($urandom_range(0, 9) == 0);
      tgt = 8'($urandom);
      step(rdy, rv, tgt);
      mv = (q_pc.size() > 0);
      mp = mv ? q_pc[0] : 8'h00;
      mi = mv ? q_in[0] : 16'h0000;
      n_tests++;
      if (out_valid !== mv || out_pc !== mp || out_instr !== mi || rom_addr !== m_pc) begin
        n_fail++;
        $display("FAIL random[%0d]: valid=%b pc=%h instr=%h addr=%h, required %b/%h/%h/%h",
                 i, out_valid, out_pc, out_instr, rom_addr, mv, mp, mi, m_pc);
      end
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    for (int a = 0; a < 256; a++) rom[a] = 16'($urandom);
    rom[8'h00] = 16'hC000;
    rom[8'h01] = 16'hC800;
    rom[8'h02] = 16'hD002;
    rom[8'h0D] = 16'h6C51;
    rom[8'hFF] = 16'h9800;

    test_reset();
    test_stream();
    test_backpressure();
    test_wrap_redirect();
    test_redirect_full();
    test_async_reset();
    test_redirect_pop_one();
    test_random();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
